// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
//             Optional macro UART_RX_PARITY_EN switches the frame to 8E1
//             and adds the perr output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int FIFO_AW          = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rxd,
    output logic [7:0]         rdata,
    output logic               rvalid,
    input  logic               rready,
    output logic               ferr,
    output logic               overrun,
`ifdef UART_RX_PARITY_EN
    output logic               perr,
`endif
    output logic [FIFO_AW:0]   count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(2 * CLK_PER_HALF_BIT);

    localparam logic [TW-1:0]      c_half_load = TW'(CLK_PER_HALF_BIT - 1);
    localparam logic [TW-1:0]      c_full_load = TW'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [FIFO_AW:0]   c_depth     = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    logic            r_meta;
    logic            r_rx_s;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_push;
    logic            r_ferr;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bit;
    logic            r_perr;
    logic            w_par_bad;

    assign w_par_bad = ^{r_shift, r_par_bit};
`endif

    // Receiver FSM; the timer reloads on every state entry and counts down to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta    <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_push    <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_meta <= rxd;
            r_rx_s <= r_meta;
            r_push <= 1'b0;
            r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_timer <= c_half_load;
                    end
                end
                S_START: begin
                    if (r_timer == '0) begin
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_timer   <= c_full_load;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_DATA: begin
                    if (r_timer == '0) begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_timer   <= c_full_load;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_timer == '0) begin
                        r_par_bit <= r_rx_s;
                        r_timer   <= c_full_load;
                        r_state   <= S_STOP;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (r_timer == '0) begin
`ifdef UART_RX_PARITY_EN
                        r_perr <= w_par_bad;
`endif
                        if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
                            r_push <= !w_par_bad;
`else
                            r_push <= 1'b1;
`endif
                            // Back to IDLE mid-stop-bit so the next start edge is caught early.
                            r_state <= S_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [7:0]          r_mem [DEPTH];
    logic [FIFO_AW-1:0]  r_wp;
    logic [FIFO_AW-1:0]  r_rp;
    logic [FIFO_AW:0]    r_count;
    logic                r_ovr;
    logic                w_pop;
    logic                w_full;
    logic                w_wr;

    assign w_pop  = rvalid && rready;
    assign w_full = (r_count == c_depth);
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign w_wr   = r_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= r_push && w_full && !w_pop;
            if (w_wr) begin
                r_wp <= r_wp + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + FIFO_AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= r_shift;
        end
    end

    assign rvalid  = (r_count != '0);
    assign rdata   = rvalid ? r_mem[r_rp] : 8'h00;
    assign count   = r_count;
    assign ferr    = r_ferr;
    assign overrun = r_ovr;
`ifdef UART_RX_PARITY_EN
    assign perr    = r_perr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Brief    : Directed self-checking bench for uart_rx_fifo with a byte-queue
//             model (honours UART_RX_PARITY_EN when defined).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int H     = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int BIT   = 2 * H;
`ifdef UART_RX_PARITY_EN
    localparam int EXTRA = 2 * H;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT_BOUND = 2 + H + 18 * H + 2 + EXTRA;
    // Edges from start-bit drive to stop-bit sample: sync 2, detect 1, start H, data 16H, stop 2H.
    localparam int PUSH_EDGE = 3 + H + 16 * H + 2 * H + EXTRA;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rxd = 1'b1;
    logic         rready = 1'b0;
    logic [7:0]   rdata;
    logic         rvalid;
    logic         ferr;
    logic         overrun;
    logic [AW:0]  count;
`ifdef UART_RX_PARITY_EN
    logic         perr;
`endif

    uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .FIFO_AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rready  (rready),
        .ferr    (ferr),
        .overrun (overrun),
`ifdef UART_RX_PARITY_EN
        .perr    (perr),
`endif
        .count   (count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  q[$];
    int          exp_ferr = 0;
    int          exp_ovr = 0;
    int          ferr_cnt = 0;
    int          ovr_cnt = 0;
    bit          quiet = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model compare on every quiet cycle, pulse counting on every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (ferr === 1'b1)    ferr_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
        end
        if (quiet) begin
            check("model_rvalid", {31'd0, rvalid}, {31'd0, q.size() != 0});
            check("model_count", {29'd0, count}, q.size());
            if (q.size() != 0) check("model_rdata", {24'd0, rdata}, {24'd0, q[0]});
            check("quiet_ferr", {31'd0, ferr}, 32'd0);
            check("quiet_overrun", {31'd0, overrun}, 32'd0);
`ifdef UART_RX_PARITY_EN
            check("quiet_perr", {31'd0, perr}, 32'd0);
`endif
        end
    end

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BIT) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_ok);
        if (!stop_ok) begin
            repeat (40) @(posedge clk);
            @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok, input bit pop_at_push);
        quiet = 1'b0;
        @(negedge clk);
        fork
            drive_frame(b, stop_ok);
            if (pop_at_push) begin
                repeat (PUSH_EDGE) @(posedge clk);
                @(negedge clk) rready = 1'b1;
                @(posedge clk);
                @(negedge clk) rready = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        if (pop_at_push && q.size() != 0) void'(q.pop_front());
        if (!stop_ok)                exp_ferr++;
        else if (q.size() < DEPTH)   q.push_back(b);
        else                         exp_ovr++;
        @(negedge clk) quiet = 1'b1;
        check("ferr_pulses", ferr_cnt, exp_ferr);
        check("overrun_pulses", ovr_cnt, exp_ovr);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        @(negedge clk);
        check(name, {24'd0, rdata}, {24'd0, exp});
        rready = 1'b1;
        @(posedge clk);
        if (q.size() != 0) void'(q.pop_front());
        @(negedge clk) rready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rvalid", {31'd0, rvalid}, 32'd0);
        check("reset_count", {29'd0, count}, 32'd0);
        check("reset_rdata", {24'd0, rdata}, 32'd0);
        check("reset_ferr", {31'd0, ferr}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        quiet = 1'b1;

        // Single byte with latency bound
        lat = 0;
        fork
            send(8'hA5, 1'b1, 1'b0);
            begin
                @(negedge clk);
                for (int i = 0; i < LAT_BOUND; i++) begin
                    @(posedge clk);
                    #1;
                    lat++;
                    if (rvalid === 1'b1) break;
                end
                check("a5_within_latency_bound", {31'd0, rvalid === 1'b1}, 32'd1);
            end
        join
        check("a5_rdata", {24'd0, rdata}, 32'h0000_00A5);
        check("a5_count", {29'd0, count}, 32'd1);
        pop_expect("a5_pop", 8'hA5);

        // Fill, overflow, drain
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        send(8'h81, 1'b1, 1'b0);
        send(8'h55, 1'b1, 1'b0);
        check("full_count", {29'd0, count}, 32'd4);
        check("one_overrun", ovr_cnt, 32'd1);
        pop_expect("drain0", 8'h00);
        pop_expect("drain1", 8'hFF);
        pop_expect("drain2", 8'h3C);
        pop_expect("drain3", 8'h81);
        @(negedge clk);
        check("drained_rvalid", {31'd0, rvalid}, 32'd0);

        // Framing error with held-low line
        send(8'h12, 1'b0, 1'b0);
        check("break_one_ferr", ferr_cnt, 32'd1);
        check("break_count", {29'd0, count}, 32'd0);
        send(8'h34, 1'b1, 1'b0);
        pop_expect("after_break_34", 8'h34);

        // Short glitch: quiet compare keeps running across it
        @(negedge clk) rxd = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rxd = 1'b1;
        repeat (4 * H) @(posedge clk);
        @(negedge clk);
        check("glitch_no_ferr", ferr_cnt, 32'd1);
        check("glitch_count", {29'd0, count}, 32'd0);

        // Push onto a full FIFO while popping in the same cycle
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        send(8'h44, 1'b1, 1'b0);
        send(8'h77, 1'b1, 1'b1);
        check("simul_no_overrun", ovr_cnt, 32'd1);
        check("simul_count", {29'd0, count}, 32'd4);
        pop_expect("simul0", 8'h22);
        pop_expect("simul1", 8'h33);
        pop_expect("simul2", 8'h44);
        pop_expect("simul3", 8'h77);

        // Reset in the middle of a data phase
        send(8'h5A, 1'b1, 1'b0);
        quiet = 1'b0;
        @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b1;
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        q.delete();
        check("post_reset_count", {29'd0, count}, 32'd0);
        check("post_reset_rvalid", {31'd0, rvalid}, 32'd0);
        repeat (3 * BIT) @(posedge clk);
        @(negedge clk) quiet = 1'b1;
        send(8'h9A, 1'b1, 1'b0);
        check("resent_9a_rdata", {24'd0, rdata}, 32'h0000_009A);
        check("resent_9a_count", {29'd0, count}, 32'd1);

        quiet = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver with a small first-word-fall-through byte FIFO.
- Sits directly upstream of the instruction loader. Program bytes arrive on rxd, are assembled and buffered, and the loader drains them through a valid/ready handshake.
- Buffering means the loader can stall for a few byte times without losing data. Drops and frame errors are reported explicitly.

Parameters:
- CLK_PER_HALF_BIT, 434, clk cycles per half UART bit period (100 MHz / 115200 baud). Minimum 2.
- FIFO_AW, 2, log2 of FIFO depth (default depth 4 bytes).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rxd  input  1  asynchronous serial line, idle high
- rdata  output  8  byte at FIFO head, valid when rvalid=1
- rvalid  output  1  FIFO non-empty
- rready  input  1  consumer accepts head byte this cycle
- ferr  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte dropped because FIFO full
- count  output  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset:
  - Synchronous, active-high, on posedge clk. Overrides all activity, including a frame in flight; the partial byte is discarded.
  - Output values: rvalid=0, ferr=0, overrun=0, count=0, rdata=0.
  - Internal state: sync flops=1, state=IDLE, FIFO pointers=0.
- Input sync: rxd passes through 2 flops (rx_s); all sampling uses rx_s.
- Bit timer: counter reloads on each state entry.
  - Half-bit wait = CLK_PER_HALF_BIT cycles.
  - Full-bit wait = 2*CLK_PER_HALF_BIT cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s=0 -> START, timer loaded for half bit.
  - START: at half-bit expiry sample rx_s. If 0 -> DATA with bit index 0. If 1, this is a glitch/false start -> IDLE, no outputs.
  - DATA: every full bit, sample rx_s into shift register, LSB first. After bit index 7 -> STOP.
  - STOP, full bit later, sample rx_s:
    - If 1: present the byte to the FIFO push logic and go to IDLE (mid-stop-bit, for early resync).
    - If 0: ferr pulses for 1 cycle, the byte is discarded, go to BREAK.
  - BREAK: wait until rx_s=1 -> IDLE. A held-low line produces exactly one ferr.
- FIFO:
  - Depth 2**FIFO_AW. Circular read/write pointers, FIFO_AW bits each, wrap modulo depth. count is tracked separately.
  - rdata is combinational from the head entry; no extra read latency.
  - Pop: rvalid&&rready.
  - Push: a valid stop bit, accepted when count<depth or when a pop occurs the same cycle.
  - Full with no pop at push time: the byte is dropped, overrun pulses for 1 cycle, FIFO contents unchanged.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - rready while empty: ignored, no pointer movement.
- Latency: rvalid rises a bounded time after the rxd falling edge.
  - Bound: ≤ 2 (sync) + CLK_PER_HALF_BIT + 18*CLK_PER_HALF_BIT + 2 cycles.
  - Pushed byte is visible on rdata/rvalid the cycle after the push.
- Receiver never blocks: FIFO state does not stall the FSM.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state is inserted between DATA and STOP, sampled one full bit after bit 7.
  - On even-parity mismatch, perr (extra 1-bit output port) pulses for 1 cycle at the stop sample and the byte is not pushed. Stop bit handling is unchanged.
  - Latency bound grows by 2*CLK_PER_HALF_BIT.
- Undefined: 8N1 as above; the perr port does not exist.

Test Plan:
- Reset, then serial byte 0xA5 at CLK_PER_HALF_BIT=4 with rready=0 -> rvalid=1, rdata=0xA5, count=1 within the latency bound; ferr=0, overrun=0.
- Bytes 0x00, 0xFF, 0x3C, 0x81, 0x55 back to back, rready=0, FIFO_AW=2:
  - First four bytes stored, count=4.
  - Fifth byte causes one overrun pulse.
  - Draining with rready=1 yields 00, FF, 3C, 81 in order, then rvalid=0.
- Frame 0x12 with stop bit forced low, rxd held low for 40 cycles, then released -> exactly one ferr pulse, count stays 0. A following 0x34 is received correctly.
- Low glitch of 2 cycles (shorter than half bit) on idle rxd -> no push, no ferr, FSM returns to IDLE.
- FIFO full (count=4) with rready=1 asserted on the same cycle a new 0x77 is pushed -> no overrun, count stays 4, 0x77 read out last.
- rst asserted mid-DATA of byte 0x9A, released, then 0x9A resent -> count=0 immediately after reset; rdata=0x9A, count=1 after the clean frame.
